// File: rtl/dma_ctrl.sv
// Single-channel word DMA: slave register port for SRC/DST/LEN/CTRL and a bus master doing read-then-write per word.
// Optional macro DMA_IRQ_EN enables the IE bit and the registered completion interrupt.
module dma_ctrl (
  input  logic        clk,
  input  logic        reset_,
  input  logic        CS_,
  input  logic        As_,
  input  logic        RW,
  input  logic [29:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Rdy_,
  output logic        mReq_,
  input  logic        mGrnt_,
  output logic [29:0] mAddr,
  output logic        mAs_,
  output logic        mRW,
  output logic [31:0] mWrData,
  input  logic [31:0] mRdData,
  input  logic        mRdy_,
  output logic        IRQ
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} stateT;

  stateT       state, stateNext;
  logic [29:0] src, dst;
  logic [15:0] len;
  logic [31:0] dataBuf;
  logic        done, doneNext;
  logic        busy;
  logic        access, wrEn, ctrlWr, start, wordDone;
  logic [31:0] readMux;
  logic        unusedBits;

  assign busy     = (state != IDLE);
  // An access is only accepted while Rdy_ is high so a held strobe is not re-sampled in its own Rdy_ cycle.
  assign access   = !CS_ && !As_ && Rdy_;
  assign wrEn     = access && !RW;
  assign ctrlWr   = wrEn && (Addr[1:0] == 2'd3);
  assign start    = ctrlWr && WrData[0] && !busy;
  assign wordDone = (state == WR) && !mRdy_;

  assign unusedBits = &{1'b0, Addr[29:2], WrData[31:30], WrData[2]};

`ifdef DMA_IRQ_EN
  logic ie, ieNext, irqReg;

  always_comb begin
    ieNext = ie;
    if (ctrlWr && !busy) ieNext = WrData[2];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ie     <= 1'b0;
      irqReg <= 1'b0;
    end else begin
      ie     <= ieNext;
      irqReg <= doneNext && ieNext;
    end
  end

  assign IRQ = irqReg;
`else
  logic ie;
  assign ie  = 1'b0;
  assign IRQ = 1'b0;
`endif

  // Setting DONE from the FSM takes priority over a software clear in the same cycle.
  always_comb begin
    doneNext = done;
    if (ctrlWr && WrData[1]) doneNext = 1'b0;
    if (state == DONE)       doneNext = 1'b1;
  end

  always_comb begin
    readMux = 32'd0;
    case (Addr[1:0])
      2'd0:    readMux = {2'b00, src};
      2'd1:    readMux = {2'b00, dst};
      2'd2:    readMux = {16'd0, len};
      default: readMux = {29'd0, ie, done, busy};
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= stateNext;
  end

  // A start with LEN=0 passes through DONE without touching the bus.
  always_comb begin
    stateNext = state;
    mReq_     = 1'b1;
    mAs_      = 1'b1;
    mRW       = 1'b1;
    mAddr     = 30'd0;
    mWrData   = 32'd0;
    case (state)
      IDLE: begin
        if (start) stateNext = (len != 16'd0) ? REQ : DONE;
      end
      REQ: begin
        mReq_ = 1'b0;
        if (!mGrnt_) stateNext = RD;
      end
      RD: begin
        mReq_ = 1'b0;
        mAs_  = 1'b0;
        mAddr = src;
        if (!mRdy_) stateNext = WR;
      end
      WR: begin
        mReq_   = 1'b0;
        mAs_    = 1'b0;
        mRW     = 1'b0;
        mAddr   = dst;
        mWrData = dataBuf;
        if (!mRdy_) stateNext = (len == 16'd1) ? DONE : RD;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      src     <= 30'd0;
      dst     <= 30'd0;
      len     <= 16'd0;
      dataBuf <= 32'd0;
      done    <= 1'b0;
      Rdy_    <= 1'b1;
      RdData  <= 32'd0;
    end else begin
      Rdy_   <= !access;
      RdData <= (access && RW) ? readMux : 32'd0;
      done   <= doneNext;

      if (wrEn && !busy && (Addr[1:0] == 2'd0)) src <= WrData[29:0];
      else if (wordDone)                         src <= src + 30'd1;

      if (wrEn && !busy && (Addr[1:0] == 2'd1)) dst <= WrData[29:0];
      else if (wordDone)                         dst <= dst + 30'd1;

      if (wrEn && !busy && (Addr[1:0] == 2'd2)) len <= WrData[15:0];
      else if (wordDone)                         len <= len - 16'd1;

      if ((state == RD) && !mRdy_) dataBuf <= mRdData;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a zero-wait memory slave and a controllable grant.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        CS_ = 1'b1, As_ = 1'b1, RW = 1'b1;
  logic [29:0] Addr = 30'd0;
  logic [31:0] WrData = 32'd0;
  logic [31:0] RdData;
  logic        Rdy_;
  logic        mReq_, mGrnt_, mAs_, mRW, mRdy_, IRQ;
  logic [29:0] mAddr;
  logic [31:0] mWrData, mRdData;
  logic        grantBlock = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_ctrl dut (
    .clk(clk), .reset_(reset_),
    .CS_(CS_), .As_(As_), .RW(RW), .Addr(Addr), .WrData(WrData),
    .RdData(RdData), .Rdy_(Rdy_),
    .mReq_(mReq_), .mGrnt_(mGrnt_), .mAddr(mAddr), .mAs_(mAs_), .mRW(mRW),
    .mWrData(mWrData), .mRdData(mRdData), .mRdy_(mRdy_), .IRQ(IRQ)
  );

  // Slave memory: zero-wait, read data is 0xA0 plus the low address byte.
  assign mGrnt_  = mReq_ | grantBlock;
  assign mRdy_   = mAs_;
  assign mRdData = 32'hA0 + {24'd0, mAddr[7:0]};

  logic [29:0] rdAddr [256];
  logic [29:0] wrAddr [256];
  logic [31:0] wrData [256];
  logic        opLog  [256];
  int rdCnt = 0, wrCnt = 0, opCnt = 0, asCycles = 0, reqCnt = 0;

  always @(posedge clk) begin
    if (!mAs_) asCycles <= asCycles + 1;
    if (!mReq_) reqCnt <= reqCnt + 1;
    if (reset_ && !mAs_ && !mRdy_) begin
      opLog[opCnt[7:0]] <= mRW;
      opCnt <= opCnt + 1;
      if (mRW) begin
        rdAddr[rdCnt[7:0]] <= mAddr;
        rdCnt <= rdCnt + 1;
      end else begin
        wrAddr[wrCnt[7:0]] <= mAddr;
        wrData[wrCnt[7:0]] <= mWrData;
        wrCnt <= wrCnt + 1;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    CS_ = 1'b0; As_ = 1'b0; RW = 1'b0; Addr = {28'd0, a}; WrData = d;
    @(posedge clk); #1;
    CS_ = 1'b1; As_ = 1'b1; RW = 1'b1; WrData = 32'd0;
  endtask

  task automatic regRead(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = {28'd0, a};
    @(posedge clk); #1;
    d = RdData;
    checkVal("rdyLow", {31'd0, Rdy_}, 32'd0);
    CS_ = 1'b1; As_ = 1'b1;
  endtask

  task automatic waitDone();
    logic [31:0] ok;
    ok = 32'd0;
    for (int i = 0; i < 200; i++) begin
      if (mReq_ === 1'b1) begin
        ok = 32'd1;
        break;
      end
      @(posedge clk); #1;
    end
    checkVal("doneTimeout", ok, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int rb, wb, ob, ab, qb;
    logic [31:0] bad;
    logic [31:0] found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstRdy", {31'd0, Rdy_}, 32'd1);
    checkVal("rstRdData", RdData, 32'd0);
    checkVal("rstReq", {31'd0, mReq_}, 32'd1);
    checkVal("rstAs", {31'd0, mAs_}, 32'd1);
    checkVal("rstRW", {31'd0, mRW}, 32'd1);
    checkVal("rstAddr", {2'd0, mAddr}, 32'd0);
    checkVal("rstWrData", mWrData, 32'd0);
    checkVal("rstIrq", {31'd0, IRQ}, 32'd0);
    reset_ = 1'b1;
    for (int r = 0; r < 4; r++) begin
      regRead(r[1:0], d);
      checkVal("rstReg", d, 32'd0);
    end
    @(posedge clk); #1;
    checkVal("rdyBackHigh", {31'd0, Rdy_}, 32'd1);
    checkVal("rdDataIdle", RdData, 32'd0);

    // Four-word copy 0x100 -> 0x200
    regWrite(2'd0, 32'h100);
    regWrite(2'd1, 32'h200);
    regWrite(2'd2, 32'd4);
    rb = rdCnt; wb = wrCnt; ob = opCnt; ab = asCycles;
    regWrite(2'd3, 32'h1);
    waitDone();
    repeat (2) @(posedge clk);
    #1;
    checkVal("cpyReads", rdCnt - rb, 32'd4);
    checkVal("cpyWrites", wrCnt - wb, 32'd4);
    checkVal("cpyCycles", asCycles - ab, 32'd8);
    for (int i = 0; i < 4; i++) begin
      checkVal("cpyRdAddr", {2'd0, rdAddr[rb + i]}, 32'h100 + i);
      checkVal("cpyWrAddr", {2'd0, wrAddr[wb + i]}, 32'h200 + i);
      checkVal("cpyWrData", wrData[wb + i], 32'hA0 + i);
    end
    for (int i = 0; i < 8; i++)
      checkVal("cpyAlt", {31'd0, opLog[ob + i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
    regRead(2'd0, d); checkVal("cpySrc", d, 32'h104);
    regRead(2'd1, d); checkVal("cpyDst", d, 32'h204);
    regRead(2'd2, d); checkVal("cpyLen", d, 32'd0);
    regRead(2'd3, d); checkVal("cpyCtrl", d, 32'h2);
    regWrite(2'd3, 32'h2);
    regRead(2'd3, d); checkVal("clrDone", d, 32'h0);

    // Zero-length start
    qb = reqCnt;
    regWrite(2'd3, 32'h1);
    regRead(2'd3, d); checkVal("zeroCtrl", d, 32'h2);
    checkVal("zeroNoReq", reqCnt - qb, 32'd0);
    regWrite(2'd3, 32'h0);
    regRead(2'd3, d); checkVal("bit1ZeroKeeps", d, 32'h2);
    regWrite(2'd3, 32'h2);

    // Grant withheld for 10 cycles
    regWrite(2'd0, 32'h10);
    regWrite(2'd1, 32'h20);
    regWrite(2'd2, 32'd1);
    grantBlock = 1'b1;
    regWrite(2'd3, 32'h1);
    bad = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (mReq_ !== 1'b0 || mAs_ !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    if (mReq_ !== 1'b0 || mAs_ !== 1'b1) bad++;
    checkVal("grantWait", bad, 32'd0);
    grantBlock = 1'b0;
    @(posedge clk); #1;
    checkVal("grantRdAs", {31'd0, mAs_}, 32'd0);
    checkVal("grantRdRW", {31'd0, mRW}, 32'd1);
    checkVal("grantRdAddr", {2'd0, mAddr}, 32'h10);
    @(posedge clk); #1;
    checkVal("grantWrRW", {31'd0, mRW}, 32'd0);
    checkVal("grantWrAddr", {2'd0, mAddr}, 32'h20);
    checkVal("grantWrData", mWrData, 32'hB0);
    checkVal("grantWrReq", {31'd0, mReq_}, 32'd0);
    @(posedge clk); #1;
    checkVal("doneReqHigh", {31'd0, mReq_}, 32'd1);
    checkVal("doneAsHigh", {31'd0, mAs_}, 32'd1);
    regRead(2'd3, d); checkVal("grantCtrl", d, 32'h2);

    // Source address wrap
    regWrite(2'd0, 32'h3FFF_FFFF);
    regWrite(2'd1, 32'h300);
    regWrite(2'd2, 32'd2);
    rb = rdCnt; wb = wrCnt;
    regWrite(2'd3, 32'h3);
    waitDone();
    repeat (2) @(posedge clk);
    #1;
    checkVal("wrapRd0", {2'd0, rdAddr[rb]}, 32'h3FFF_FFFF);
    checkVal("wrapRd1", {2'd0, rdAddr[rb + 1]}, 32'h0);
    checkVal("wrapWd0", wrData[wb], 32'h19F);
    checkVal("wrapWd1", wrData[wb + 1], 32'hA0);
    checkVal("wrapWa1", {2'd0, wrAddr[wb + 1]}, 32'h301);
    regRead(2'd0, d); checkVal("wrapSrc", d, 32'h1);

    // Clear write landing on the DONE cycle loses to the set
    regWrite(2'd2, 32'd1);
    regWrite(2'd3, 32'h2);
    regWrite(2'd3, 32'h1);
    repeat (2) @(posedge clk);
    regWrite(2'd3, 32'h2);
    regRead(2'd3, d); checkVal("doneWins", d, 32'h2);

    // Interrupt
    regWrite(2'd3, 32'h2);
    regWrite(2'd2, 32'd1);
    regWrite(2'd3, 32'h5);
    waitDone();
    repeat (2) @(posedge clk);
    #1;
`ifdef DMA_IRQ_EN
    checkVal("irqSet", {31'd0, IRQ}, 32'd1);
    regRead(2'd3, d); checkVal("irqCtrl", d, 32'h6);
    regWrite(2'd3, 32'h6);
    checkVal("irqClr", {31'd0, IRQ}, 32'd0);
    regRead(2'd3, d); checkVal("irqCtrlClr", d, 32'h4);
`else
    checkVal("irqOff", {31'd0, IRQ}, 32'd0);
    regRead(2'd3, d); checkVal("irqCtrl", d, 32'h2);
    regWrite(2'd3, 32'h6);
    checkVal("irqOffClr", {31'd0, IRQ}, 32'd0);
    regRead(2'd3, d); checkVal("irqCtrlClr", d, 32'h0);
`endif

    // Reset during the write of word 2 of 4
    regWrite(2'd0, 32'h100);
    regWrite(2'd1, 32'h200);
    regWrite(2'd2, 32'd4);
    wb = wrCnt;
    regWrite(2'd3, 32'h1);
    found = 32'd0;
    for (int i = 0; i < 50; i++) begin
      if (!mAs_ && !mRW && mAddr == 30'h201) begin
        found = 32'd1;
        break;
      end
      @(posedge clk); #1;
    end
    checkVal("w2Found", found, 32'd1);
    reset_ = 1'b0;
    #1;
    checkVal("midRstAs", {31'd0, mAs_}, 32'd1);
    checkVal("midRstReq", {31'd0, mReq_}, 32'd1);
    checkVal("midRstAddr", {2'd0, mAddr}, 32'd0);
    checkVal("midRstWrData", mWrData, 32'd0);
    checkVal("midRstIrq", {31'd0, IRQ}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    qb = reqCnt;
    repeat (5) @(posedge clk);
    #1;
    checkVal("midRstNoReq", reqCnt - qb, 32'd0);
    checkVal("midRstWrites", wrCnt - wb, 32'd1);
    for (int r = 0; r < 4; r++) begin
      regRead(r[1:0], d);
      checkVal("midRstReg", d, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock, rising edge; reset_  in  1  asynchronous active-low reset.
REQ-002 SHALL provide slave config port: CS_ in 1 chip select (low); As_ in 1 address strobe (low); RW in 1 (1=read, 0=write); Addr in 30 word address, only [1:0] decoded; WrData in 32; RdData out 32; Rdy_ out 1 ready (low).
REQ-003 SHALL provide master port: mReq_ out 1 bus request (low); mGrnt_ in 1 grant (low); mAddr out 30; mAs_ out 1; mRW out 1; mWrData out 32; mRdData in 32; mRdy_ in 1.
REQ-004 SHALL provide IRQ out 1, active high, completion interrupt.

Function
REQ-005 SHALL decode registers on Addr[1:0]: 0 SRC[29:0], 1 DST[29:0], 2 LEN[15:0] word count, 3 CTRL (bit0 START/BUSY, bit1 DONE, bit2 IE); unused bits read 0.
REQ-006 Slave access SHALL complete one cycle after CS_=0 and As_=0 sampled: Rdy_ low for exactly one cycle, RdData registered, RdData=0 when Rdy_ high.
REQ-007 Writes to SRC/DST/LEN/IE while BUSY=1 SHALL be ignored; writing CTRL bit0=1 while BUSY=1 SHALL be ignored.
REQ-008 Writing CTRL bit1=1 SHALL clear DONE; writing bit1=0 SHALL leave it unchanged.
REQ-009 FSM states SHALL be IDLE, REQ, RD, WR, DONE.
REQ-010 IDLE: on CTRL write with bit0=1 and LEN!=0 -> REQ, BUSY=1; with LEN=0 -> DONE set next cycle, no bus request issued.
REQ-011 REQ: mReq_=0; on mGrnt_=0 sampled -> RD.
REQ-012 RD: mAs_=0, mRW=1, mAddr=SRC; on mRdy_=0 capture mRdData into 32-bit buffer -> WR.
REQ-013 WR: mAs_=0, mRW=0, mAddr=DST, mWrData=buffer; on mRdy_=0: SRC+=1, DST+=1, LEN-=1; LEN becomes 0 -> DONE, else -> RD with mReq_ held low.
REQ-014 DONE (one cycle): mReq_=1, BUSY=0, DONE=1 -> IDLE.
REQ-015 Master outputs outside RD/WR SHALL be mAs_=1, mAddr=0, mRW=1, mWrData=0.
REQ-016 SRC/DST increments SHALL wrap modulo 2^30 without error.
REQ-017 mReq_ SHALL stay low from REQ entry through the last WR completion; no arbitration release mid-transfer.
REQ-018 Slave access and DONE set in the same cycle: DONE set SHALL win over a clear write.
REQ-019 Word throughput SHALL be bounded by slave latency: minimum 2 cycles per word with single-cycle Rdy_.

Reset
REQ-020 On reset_=0, immediately: state=IDLE, SRC=DST=0, LEN=0, CTRL=0, buffer=0, Rdy_=1, RdData=0, mReq_=1, mAs_=1, mRW=1, mAddr=0, mWrData=0, IRQ=0.
REQ-021 Reset mid-transfer SHALL abandon the transfer with no further bus activity; registers hold reset values.

Configuration
REQ-022 Macro DMA_IRQ_EN: defined -> IRQ = DONE AND IE, registered, cleared with DONE; undefined -> IRQ tied 0, IE bit reads 0, writes ignored.

Verification
REQ-023 SRC=0x100, DST=0x200, LEN=4, START; slave memory 0xA0..0xA3 -> 4 reads then writes alternate, DST words match, final SRC=0x104, DST=0x204, LEN=0, DONE=1.
REQ-024 LEN=0, START -> mReq_ never low, DONE=1 within 2 cycles, BUSY=0.
REQ-025 mGrnt_ withheld 10 cycles -> mReq_ low, mAs_ high throughout; transfer starts the cycle after grant.
REQ-026 SRC=0x3FFFFFFF, LEN=2 -> second read at mAddr=0x00000000.
REQ-027 reset_ pulsed low during WR of word 2 of 4 -> mAs_/mReq_ high immediately, all registers read 0 afterward.
REQ-028 DMA_IRQ_EN defined, IE=1, LEN=1 -> IRQ=1 after DONE; write CTRL bit1=1 -> IRQ=0 next cycle; undefined -> IRQ stays 0.
